// File: rtl/prog_loader.sv
// prog_loader: 16x8 program RAM loaded from a framed byte stream (len, data, checksum);
// holds the SAP core in reset until a load completes with a matching checksum.
module prog_loader (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       rd_en,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       cpu_reset,
    output logic       busy,
    output logic       done,
    output logic       err
);
    typedef enum logic [2:0] {S_IDLE, S_HDR, S_DATA, S_CHK, S_RUN, S_ERR} state_t;

    state_t     r_state, w_next;
    logic [7:0] r_mem [16];
    logic [3:0] r_addr, r_len;
    logic [7:0] r_sum;
    logic       w_xfer, w_last;

    assign w_xfer = in_valid && in_ready;
    // len=0 encodes 16, so the last index is len-1 in 4-bit arithmetic
    assign w_last = r_addr == r_len - 4'd1;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = start ? S_HDR : S_IDLE;
            S_HDR:   w_next = w_xfer ? S_DATA : S_HDR;
            S_DATA:  w_next = (w_xfer && w_last) ? S_CHK : S_DATA;
            S_CHK:   w_next = w_xfer ? ((in_data == r_sum) ? S_RUN : S_ERR) : S_CHK;
            S_RUN:   w_next = start ? S_HDR : S_RUN;
            S_ERR:   w_next = start ? S_HDR : S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    assign busy      = r_state == S_HDR || r_state == S_DATA || r_state == S_CHK;
    assign in_ready  = busy;
    assign cpu_reset = r_state != S_RUN;
    assign done      = r_state == S_RUN;
    assign err       = r_state == S_ERR;
    assign rd_data   = rd_en ? r_mem[rd_addr] : 8'h00;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_addr  <= 4'd0;
            r_sum   <= 8'h00;
            r_len   <= 4'd0;
            for (int i = 0; i < 16; i++) r_mem[i] <= 8'h00;
        end else begin
            r_state <= w_next;
            if (r_state == S_HDR && w_xfer) begin
                r_len  <= in_data[3:0];
                r_addr <= 4'd0;
                r_sum  <= 8'h00;
            end
            if (r_state == S_DATA && w_xfer) begin
                r_mem[r_addr] <= in_data;
                r_sum         <= r_sum + in_data;
                r_addr        <= r_addr + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed scenarios for the framed program loader, with hand-computed
// checksums and memory images.
module tb_prog_loader;
    logic       clk = 0, reset = 0, start = 0, in_valid = 0, rd_en = 0;
    logic [7:0] in_data = 0;
    logic [3:0] rd_addr = 0;
    logic       in_ready, cpu_reset, busy, done, err;
    logic [7:0] rd_data;
    int         tests = 0, fails = 0, n_edges = 0;

    logic [7:0] frame_ok  [7] = '{8'h05, 8'h6E, 8'h71, 8'h4E, 8'h00, 8'h14, 8'h41};
    logic [7:0] image_ok  [5] = '{8'h6E, 8'h71, 8'h4E, 8'h00, 8'h14};

    prog_loader dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) if (in_valid && in_ready) n_edges++;

    task automatic xfer(input logic [7:0] b);
        int k = 0;
        @(negedge clk);
        in_valid = 1;
        in_data  = b;
        #1;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        tests++;
        if (!in_ready) begin
            fails++;
            $display("FAIL xfer_timeout byte=%h in_ready=%b expected 1", b, in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic read(input logic [3:0] a, output logic [7:0] d);
        @(negedge clk);
        rd_en   = 1;
        rd_addr = a;
        #1;
        d = rd_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        @(negedge clk);
        reset = 1;
        start = 1;
        @(posedge clk);
        #1;
        reset = 0;
        start = 0;
        @(negedge clk);
        tests++;
        if ({cpu_reset, busy, done, err, in_ready} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_outputs got=%b expected 10000", {cpu_reset, busy, done, err, in_ready});
        end
        for (int a = 0; a < 16; a++) begin
            read(a[3:0], d);
            tests++;
            if (d !== 8'h00) begin
                fails++;
                $display("FAIL reset_mem addr=%0d got=%h expected 00", a, d);
            end
        end
        @(negedge clk);
        rd_en = 0;
        #1;
        tests++;
        if (rd_data !== 8'h00) begin
            fails++;
            $display("FAIL rd_en_low got=%h expected 00", rd_data);
        end
    endtask

    task automatic load_frame_ok();
        pulse_start();
        for (int i = 0; i < 7; i++) xfer(frame_ok[i]);
    endtask

    task automatic check_image_ok(input string name, input logic [7:0] tail);
        logic [7:0] d, exp;
        for (int a = 0; a < 16; a++) begin
            exp = (a < 5) ? image_ok[a] : tail;
            read(a[3:0], d);
            tests++;
            if (d !== exp) begin
                fails++;
                $display("FAIL %s_mem addr=%0d got=%h expected %h", name, a, d, exp);
            end
        end
    endtask

    task automatic test_load();
        int e0;
        @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL idle_ready got=%b expected 0", in_ready);
        end
        pulse_start();
        @(negedge clk);
        tests++;
        if ({in_ready, busy, cpu_reset} !== 3'b111) begin
            fails++;
            $display("FAIL hdr_outputs got=%b expected 111", {in_ready, busy, cpu_reset});
        end
        e0 = n_edges;
        for (int i = 0; i < 7; i++) xfer(frame_ok[i]);
        @(negedge clk);
        tests++;
        if ({done, cpu_reset, err, busy, in_ready} !== 5'b10000 || n_edges - e0 != 7) begin
            fails++;
            $display("FAIL load_done got=%b xfers=%0d expected 10000 xfers=7",
                     {done, cpu_reset, err, busy, in_ready}, n_edges - e0);
        end
        check_image_ok("load", 8'h00);
    endtask

    task automatic test_bad_checksum();
        pulse_start();
        for (int i = 0; i < 6; i++) xfer(frame_ok[i]);
        xfer(8'h42);
        @(negedge clk);
        tests++;
        if ({err, done, cpu_reset, busy} !== 4'b1010) begin
            fails++;
            $display("FAIL bad_chk got=%b expected 1010", {err, done, cpu_reset, busy});
        end
        check_image_ok("bad_chk", 8'h00);
        load_frame_ok();
        @(negedge clk);
        tests++;
        if ({done, err, cpu_reset} !== 3'b100) begin
            fails++;
            $display("FAIL recover got=%b expected 100", {done, err, cpu_reset});
        end
    endtask

    task automatic test_full16();
        logic [7:0] d;
        int e0;
        pulse_start();
        e0 = n_edges;
        xfer(8'h00);
        for (int i = 0; i < 16; i++) xfer(8'h11);
        xfer(8'h10);
        @(negedge clk);
        in_valid = 1;
        in_data  = 8'h99;
        #1;
        tests++;
        if ({done, cpu_reset, in_ready} !== 3'b100) begin
            fails++;
            $display("FAIL full16_done got=%b expected 100", {done, cpu_reset, in_ready});
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        tests++;
        if (n_edges - e0 != 18) begin
            fails++;
            $display("FAIL full16_xfers got=%0d expected 18", n_edges - e0);
        end
        for (int a = 0; a < 16; a++) begin
            read(a[3:0], d);
            tests++;
            if (d !== 8'h11) begin
                fails++;
                $display("FAIL full16_mem addr=%0d got=%h expected 11", a, d);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        pulse_start();
        xfer(frame_ok[0]);
        for (int i = 1; i < 7; i++) begin
            xfer(frame_ok[i]);
            if (i < 6) begin
                @(negedge clk);
                start = 1;
                @(negedge clk);
                start = 0;
                #1;
                tests++;
                if ({busy, in_ready, cpu_reset, done} !== 4'b1110) begin
                    fails++;
                    $display("FAIL stall_busy i=%0d got=%b expected 1110", i,
                             {busy, in_ready, cpu_reset, done});
                end
            end
        end
        @(negedge clk);
        tests++;
        if ({done, cpu_reset, err} !== 3'b100) begin
            fails++;
            $display("FAIL stall_done got=%b expected 100", {done, cpu_reset, err});
        end
        check_image_ok("stall", 8'h00);
    endtask

    task automatic test_midload_reset();
        logic [7:0] d;
        do_reset();
        pulse_start();
        xfer(frame_ok[0]);
        read(4'd0, d);
        in_valid = 1;
        in_data  = 8'h6E;
        #1;
        tests++;
        if (d !== 8'h00 || rd_data !== 8'h00) begin
            fails++;
            $display("FAIL same_cycle_read got=%h expected 00", rd_data);
        end
        @(posedge clk);
        #1;
        in_valid = 0;
        tests++;
        if (rd_data !== 8'h6E) begin
            fails++;
            $display("FAIL post_write_read got=%h expected 6E", rd_data);
        end
        xfer(frame_ok[2]);
        xfer(frame_ok[3]);
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        tests++;
        if ({cpu_reset, in_ready, busy, done, err} !== 5'b10000) begin
            fails++;
            $display("FAIL midload_reset got=%b expected 10000", {cpu_reset, in_ready, busy, done, err});
        end
        for (int a = 0; a < 16; a++) begin
            read(a[3:0], d);
            tests++;
            if (d !== 8'h00) begin
                fails++;
                $display("FAIL midload_mem addr=%0d got=%h expected 00", a, d);
            end
        end
    endtask

    task automatic test_reload_from_run();
        logic [7:0] d;
        load_frame_ok();
        pulse_start();
        @(negedge clk);
        tests++;
        if ({cpu_reset, busy, done} !== 3'b110) begin
            fails++;
            $display("FAIL reload_session got=%b expected 110", {cpu_reset, busy, done});
        end
        xfer(8'h01);
        xfer(8'hAB);
        @(negedge clk);
        tests++;
        if ({cpu_reset, in_ready} !== 2'b11) begin
            fails++;
            $display("FAIL reload_chk_wait got=%b expected 11", {cpu_reset, in_ready});
        end
        xfer(8'hAB);
        @(negedge clk);
        tests++;
        if ({done, cpu_reset, err} !== 3'b100) begin
            fails++;
            $display("FAIL reload_done got=%b expected 100", {done, cpu_reset, err});
        end
        read(4'd0, d);
        tests++;
        if (d !== 8'hAB) begin
            fails++;
            $display("FAIL reload_addr0 got=%h expected AB", d);
        end
        for (int a = 1; a < 5; a++) begin
            read(a[3:0], d);
            tests++;
            if (d !== image_ok[a]) begin
                fails++;
                $display("FAIL reload_keep addr=%0d got=%h expected %h", a, d, image_ok[a]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_bad_checksum();
        test_full16();
        test_stall();
        test_midload_reset();
        test_reload_from_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program-memory writer for the SAP core: a 16x8 RAM with a byte-stream load port and a CPU-side read port. A host streams a framed program image (length, data bytes, checksum) in over a valid/ready handshake. The block writes the image into RAM and holds the CPU in reset until a load completes with a good checksum. It is the writable replacement for the fixed program ROM; the CPU fetches through the read port exactly as it addresses the ROM.

## Interface
- No parameters. Depth is fixed at 16 words, width at 8 bits.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a load session; sampled each posedge.
- in_valid  in  1  host presents in_data.
- in_data  in  8  stream byte.
- in_ready  out  1  block accepts in_data this cycle.
- rd_en  in  1  CPU read enable.
- rd_addr  in  4  CPU read address.
- rd_data  out  8  mem[rd_addr] when rd_en, else 8'h00; combinational.
- cpu_reset  out  1  holds the SAP core in reset.
- busy  out  1  load session in progress.
- done  out  1  last load succeeded; CPU released.
- err  out  1  last load failed checksum.

## Operation
- States: IDLE, HDR, DATA, CHK, RUN, ERR. cpu_reset, busy, done, err and in_ready decode from the state register only.
- A transfer occurs at a posedge where in_valid && in_ready. No other edge consumes a byte.
- IDLE: in_ready=0, cpu_reset=1. start moves to HDR.
- HDR: in_ready=1. On transfer: len = in_data[3:0], where 0 encodes 16; in_data[7:4] is ignored. addr=0, sum=0, next DATA.
- DATA: in_ready=1. On transfer: mem[addr] <= in_data, sum <= sum + in_data (mod 256), addr++. After the len-th byte, next CHK.
- CHK: in_ready=1. On transfer: if in_data == sum then RUN, else ERR.
- RUN: cpu_reset=0, done=1. start moves to HDR and reasserts cpu_reset.
- ERR: err=1, cpu_reset=1. start moves to HDR.
- busy=1 in HDR, DATA and CHK. cpu_reset=1 in every state except RUN.
- start is ignored in HDR, DATA and CHK.
- Locations at or beyond len keep their previous contents; a new session does not clear memory.
- Reads are legal in every state and return current contents, including partially loaded data.
- addr is 4 bits. With len=16 it wraps 15->0 exactly as DATA exits, so there is no extra write.

## Timing
- Reset, any state, including mid-load: state=IDLE, all 16 words=8'h00, addr=0, sum=0, len=0. Outputs: cpu_reset=1, busy=0, done=0, err=0, in_ready=0.
- start in IDLE at edge N: in_ready=1 from cycle N+1.
- Write latency: a byte transferred at edge N is visible on rd_data after edge N (same-cycle read returns the old value).
- Checksum byte accepted at edge N: cpu_reset falls (or err rises) immediately after edge N.
- Minimum session: 1+len+1 transfer cycles with no gaps. in_valid gaps and in_ready are independent; stalls do not alter addr, sum or the state.
- start and reset on the same edge: reset wins.

## Test plan
- Load frame 05 6E 71 4E 00 14 41 back-to-back -> 7 transfers. After the last, done=1, cpu_reset=0, err=0. Reading addr 0..4 gives 6E 71 4E 00 14; addr 5..15 give 00.
- Same frame with checksum 42 -> err=1, done=0, cpu_reset=1. Memory still holds 6E 71 4E 00 14. start followed by a correct frame -> done=1.
- Frame 00 followed by 16 bytes of 11, checksum 10 -> done=1 and all 16 words read 11. Exactly 18 transfers occur; the next in_valid is not accepted (in_ready=0).
- Same 5-byte frame with in_valid toggling 1,0,0,1 and start pulsed during DATA -> identical end result to the first scenario; start has no effect.
- reset asserted after the third data byte -> next cycle: IDLE, every word 00, cpu_reset=1, in_ready=0, busy=0.
- From RUN, start and load 01 AB AB -> cpu_reset=1 during the session, then addr0=AB while addr1..4 keep 71 4E 00 14. Ends with done=1.
